// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and the
// bit-counter width helper.
package serial_adder_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Counter must be able to hold WIDTH itself, not just WIDTH-1.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/Half_add.sv
// Half-adder cell shared by the arithmetic blocks: sum = a ^ b, carry = a & b.
module Half_add (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b;
    assign carry = a & b;

endmodule

// File: rtl/serial_adder_full_add_bit.sv
// One-bit full adder built from two Half_add cells; the two partial carries
// can never both be high, so an OR merges them.
module full_add_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic ha0_sum;
    logic ha0_carry;
    logic ha1_carry;

    Half_add u_ha0 (
        .a     (a),
        .b     (b),
        .sum   (ha0_sum),
        .carry (ha0_carry)
    );

    Half_add u_ha1 (
        .a     (ha0_sum),
        .b     (cin),
        .sum   (sum),
        .carry (ha1_carry)
    );

    assign cout = ha0_carry | ha1_carry;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder, LSB first, one bit per clock with a done strobe.
// Define SERIAL_ADDER_CIN_EN to add a cin port that seeds the carry flop.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef SERIAL_ADDER_CIN_EN
    input  logic             cin,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // state    | meaning
    // ST_IDLE  | waiting for start; sum/cout hold last result
    // ST_SHIFT | one operand bit added per edge, LSB first
    // ST_DONE  | single-cycle done strobe, then back to idle

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             cin_init;
    logic             fa_sum;
    logic             fa_cout;
    logic             accept;
    logic             last_bit;

`ifdef SERIAL_ADDER_CIN_EN
    assign cin_init = cin;
`else
    assign cin_init = 1'b0;
`endif

    full_add_bit u_fa (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .cin  (carry_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    assign accept   = (state_q == ST_IDLE) && start;
    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_SHIFT;
            ST_SHIFT: if (last_bit) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == ST_SHIFT) || (state_q == ST_DONE);
        done = (state_q == ST_DONE);
    end

    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        if (accept) begin
            a_d     = a;
            b_d     = b;
            sum_d   = '0;
            cnt_d   = '0;
            carry_d = cin_init;
            cout_d  = 1'b0;
        end else if (state_q == ST_SHIFT) begin
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            // Shift form keeps WIDTH=1 legal (no zero-width slices).
            sum_d   = (sum_q >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));
            cnt_d   = cnt_q + CNT_W'(1);
            carry_d = fa_cout;
            if (last_bit) begin
                cout_d = fa_cout;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule
